// File: rtl/step0_twiddle_mul_if.sv
// ----------------------------------------------------------------------------
// step0_twiddle_mul_if
//   Beat bus between the stage-0 second butterfly, the stage-0 twiddle
//   multiplier and the stage-1 shift-register/butterfly pair.
//   Lane l of every array is element [l] of the packed vector.
//
//   din_valid          input beat valid (no backpressure)
//   din_add_r/i        add-path real/imag, DIN_W per lane
//   din_sub_r/i        sub-path real/imag, DIN_W per lane
//   dout_valid         output beat valid
//   dout_frame_start   high with output beat 0 of each frame
//   dout_add_r/i       add path, sign-extended and delayed, DOUT_W per lane
//   dout_sub_r/i       sub path times twiddle, DOUT_W per lane
//
//   Modports: master = beat source / sink side, slave = multiplier.
// ----------------------------------------------------------------------------
interface step0_twiddle_mul_if #(
    parameter int unsigned DIN_W  = 13,
    parameter int unsigned DOUT_W = 14,
    parameter int unsigned LANES  = 16
);
    logic                          din_valid;
    logic [LANES-1:0][DIN_W-1:0]   din_add_r;
    logic [LANES-1:0][DIN_W-1:0]   din_add_i;
    logic [LANES-1:0][DIN_W-1:0]   din_sub_r;
    logic [LANES-1:0][DIN_W-1:0]   din_sub_i;
    logic                          dout_valid;
    logic                          dout_frame_start;
    logic [LANES-1:0][DOUT_W-1:0]  dout_add_r;
    logic [LANES-1:0][DOUT_W-1:0]  dout_add_i;
    logic [LANES-1:0][DOUT_W-1:0]  dout_sub_r;
    logic [LANES-1:0][DOUT_W-1:0]  dout_sub_i;

    modport master (
        output din_valid, din_add_r, din_add_i, din_sub_r, din_sub_i,
        input  dout_valid, dout_frame_start, dout_add_r, dout_add_i, dout_sub_r, dout_sub_i
    );

    modport slave (
        input  din_valid, din_add_r, din_add_i, din_sub_r, din_sub_i,
        output dout_valid, dout_frame_start, dout_add_r, dout_add_i, dout_sub_r, dout_sub_i
    );
endinterface

// File: rtl/step0_twiddle_mul.sv
// ----------------------------------------------------------------------------
// step0_twiddle_mul
//   Stage-0 twiddle multiplier of the 512-point DIF FFT. Each valid beat
//   carries 16 add lanes and 16 sub lanes; sub lane l of beat b is multiplied
//   by W512^(16*b+l), add lanes are sign-extended and passed with the same
//   3-cycle latency. A frame is 16 valid beats; beat_cnt is the only frame
//   sync and starts at 0 after reset.
//
//   Ports
//     clk      rising-edge clock
//     rstn     asynchronous active-low reset
//     bus_io   step0_twiddle_mul_if.slave (din_* in, dout_* out)
//
//   Build option
//     STEP0_TW_ROUND_EN  defined: add 2**7 before the >>>8 (round half up)
//                        undefined: plain >>>8 (floor)
// ----------------------------------------------------------------------------
module step0_twiddle_mul #(
    parameter int unsigned DIN_W  = 13,
    parameter int unsigned TW_W   = 10,
    parameter int unsigned DOUT_W = 14,
    parameter int unsigned LANES  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    step0_twiddle_mul_if.slave  bus_io
);

    localparam int unsigned NumTw = 256;
    localparam int unsigned PW    = DIN_W + TW_W;  // single product width
    localparam int unsigned SW    = PW + 1;        // sum/difference width
    localparam int unsigned Shift = TW_W - 2;      // unity = 2**Shift
    localparam real         Pi    = 3.14159265358979323846;

`ifdef STEP0_TW_ROUND_EN
    localparam logic signed [SW-1:0] Rnd = SW'(1 << (Shift - 1));
`else
    localparam logic signed [SW-1:0] Rnd = '0;
`endif

    // Elaboration-time twiddle table: entry n = round(unity*cos) or
    // -round(unity*sin) of 2*pi*n/512, rounded symmetrically about zero.
    function automatic logic [NumTw*TW_W-1:0] build_tw(input bit im);
        logic [NumTw*TW_W-1:0] t;
        real                   ang;
        real                   v;
        int                    iv;
        t = '0;
        for (int n = 0; n < NumTw; n++) begin
            ang = 2.0 * Pi * real'(n) / 512.0;
            v   = im ? -real'(1 << Shift) * $sin(ang) : real'(1 << Shift) * $cos(ang);
            iv  = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
            t[n*TW_W +: TW_W] = iv[TW_W-1:0];
        end
        return t;
    endfunction

    localparam logic [NumTw*TW_W-1:0] TwRe = build_tw(1'b0);
    localparam logic [NumTw*TW_W-1:0] TwIm = build_tw(1'b1);

    // Frame position and valid pipeline
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       v1_q, v2_q, v3_q;
    logic       first1_q, first2_q, first3_q;

    // S1: registered inputs and twiddles
    logic signed [DIN_W-1:0] s1_add_r_q [LANES];
    logic signed [DIN_W-1:0] s1_add_i_q [LANES];
    logic signed [DIN_W-1:0] s1_sub_r_q [LANES];
    logic signed [DIN_W-1:0] s1_sub_i_q [LANES];
    logic signed [TW_W-1:0]  s1_wr_q    [LANES];
    logic signed [TW_W-1:0]  s1_wi_q    [LANES];
    logic signed [TW_W-1:0]  wr_d       [LANES];
    logic signed [TW_W-1:0]  wi_d       [LANES];

    // S2: registered partial products
    logic signed [DIN_W-1:0] s2_add_r_q [LANES];
    logic signed [DIN_W-1:0] s2_add_i_q [LANES];
    logic signed [PW-1:0]    s2_prr_q   [LANES];
    logic signed [PW-1:0]    s2_pii_q   [LANES];
    logic signed [PW-1:0]    s2_pri_q   [LANES];
    logic signed [PW-1:0]    s2_pir_q   [LANES];
    logic signed [PW-1:0]    prr_d      [LANES];
    logic signed [PW-1:0]    pii_d      [LANES];
    logic signed [PW-1:0]    pri_d      [LANES];
    logic signed [PW-1:0]    pir_d      [LANES];

    // S3: output registers
    logic signed [SW-1:0]          re_d [LANES];
    logic signed [SW-1:0]          im_d [LANES];
    logic [LANES-1:0][DOUT_W-1:0]  s3_add_r_q, s3_add_i_q, s3_sub_r_q, s3_sub_i_q;
    logic [LANES-1:0][DOUT_W-1:0]  add_r_d, add_i_d, sub_r_d, sub_i_d;

    assign beat_cnt_d = beat_cnt_q + 4'd1;  // wraps 15 -> 0

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            // n = 16*beat + lane
            wr_d[l]  = TwRe[(int'(beat_cnt_q) * LANES + l) * TW_W +: TW_W];
            wi_d[l]  = TwIm[(int'(beat_cnt_q) * LANES + l) * TW_W +: TW_W];

            prr_d[l] = PW'(s1_sub_r_q[l]) * PW'(s1_wr_q[l]);
            pii_d[l] = PW'(s1_sub_i_q[l]) * PW'(s1_wi_q[l]);
            pri_d[l] = PW'(s1_sub_r_q[l]) * PW'(s1_wi_q[l]);
            pir_d[l] = PW'(s1_sub_i_q[l]) * PW'(s1_wr_q[l]);

            re_d[l]  = SW'(s2_prr_q[l]) - SW'(s2_pii_q[l]);
            im_d[l]  = SW'(s2_pri_q[l]) + SW'(s2_pir_q[l]);

            // |in| <= 4096 bounds |out| below 2**13, so truncation cannot wrap
            sub_r_d[l] = DOUT_W'((re_d[l] + Rnd) >>> Shift);
            sub_i_d[l] = DOUT_W'((im_d[l] + Rnd) >>> Shift);
            add_r_d[l] = DOUT_W'(s2_add_r_q[l]);
            add_i_d[l] = DOUT_W'(s2_add_i_q[l]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            first1_q   <= 1'b0;
            first2_q   <= 1'b0;
            first3_q   <= 1'b0;
            s3_add_r_q <= '0;
            s3_add_i_q <= '0;
            s3_sub_r_q <= '0;
            s3_sub_i_q <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_add_r_q[l] <= '0;
                s1_add_i_q[l] <= '0;
                s1_sub_r_q[l] <= '0;
                s1_sub_i_q[l] <= '0;
                s1_wr_q[l]    <= '0;
                s1_wi_q[l]    <= '0;
                s2_add_r_q[l] <= '0;
                s2_add_i_q[l] <= '0;
                s2_prr_q[l]   <= '0;
                s2_pii_q[l]   <= '0;
                s2_pri_q[l]   <= '0;
                s2_pir_q[l]   <= '0;
            end
        end else begin
            v1_q <= bus_io.din_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;

            if (bus_io.din_valid) begin
                beat_cnt_q <= beat_cnt_d;
                first1_q   <= (beat_cnt_q == 4'd0);
                for (int l = 0; l < LANES; l++) begin
                    s1_add_r_q[l] <= bus_io.din_add_r[l];
                    s1_add_i_q[l] <= bus_io.din_add_i[l];
                    s1_sub_r_q[l] <= bus_io.din_sub_r[l];
                    s1_sub_i_q[l] <= bus_io.din_sub_i[l];
                    s1_wr_q[l]    <= wr_d[l];
                    s1_wi_q[l]    <= wi_d[l];
                end
            end

            if (v1_q) begin
                first2_q <= first1_q;
                for (int l = 0; l < LANES; l++) begin
                    s2_add_r_q[l] <= s1_add_r_q[l];
                    s2_add_i_q[l] <= s1_add_i_q[l];
                    s2_prr_q[l]   <= prr_d[l];
                    s2_pii_q[l]   <= pii_d[l];
                    s2_pri_q[l]   <= pri_d[l];
                    s2_pir_q[l]   <= pir_d[l];
                end
            end

            if (v2_q) begin
                first3_q   <= first2_q;
                s3_add_r_q <= add_r_d;
                s3_add_i_q <= add_i_d;
                s3_sub_r_q <= sub_r_d;
                s3_sub_i_q <= sub_i_d;
            end
        end
    end

    assign bus_io.dout_valid       = v3_q;
    assign bus_io.dout_frame_start = v3_q & first3_q;
    assign bus_io.dout_add_r       = s3_add_r_q;
    assign bus_io.dout_add_i       = s3_add_i_q;
    assign bus_io.dout_sub_r       = s3_sub_r_q;
    assign bus_io.dout_sub_i       = s3_sub_i_q;

endmodule

// File: tb/tb_step0_twiddle_mul.sv
// ----------------------------------------------------------------------------
// tb_step0_twiddle_mul
//   Directed bench for step0_twiddle_mul. A behavioural model computes every
//   output beat from the twiddle definition with real-valued cos/sin and plain
//   integer arithmetic; one compare process checks each cycle. Literal checks
//   pin the model on the hand-computed cases.
// ----------------------------------------------------------------------------
module tb_step0_twiddle_mul;

    localparam real Pi = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    step0_twiddle_mul_if #(.DIN_W(13), .DOUT_W(14), .LANES(16)) bus ();

    step0_twiddle_mul dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus)
    );

    typedef struct {
        int                 due;
        bit                 fs;
        logic [15:0][13:0]  sr;
        logic [15:0][13:0]  si;
        logic [15:0][13:0]  ar;
        logic [15:0][13:0]  ai;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   mbeat = 0;
    int   total = 0;
    int   bad = 0;
    int   fs_cnt = 0;
    int   out_idx = 0;
    int   fs_pos[$];

    function automatic int rnd_sym(input real v);
        return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    endfunction

    // Complex product of one sample with W512^n, scaled back by 256
    function automatic void model_lane(input int ar, input int ai, input int n,
                                       output int yr, output int yi);
        real    ang;
        int     wr, wi;
        longint re, im, rb;
        ang = 2.0 * Pi * real'(n) / 512.0;
        wr  = rnd_sym(256.0 * $cos(ang));
        wi  = -rnd_sym(256.0 * $sin(ang));
        re  = longint'(ar) * wr - longint'(ai) * wi;
        im  = longint'(ar) * wi + longint'(ai) * wr;
`ifdef STEP0_TW_ROUND_EN
        rb = 128;
`else
        rb = 0;
`endif
        yr = int'((re + rb) >>> 8);
        yi = int'((im + rb) >>> 8);
    endfunction

    task automatic chk_v(input string nm, input logic [223:0] act, input logic [223:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_l(input string nm, input logic [13:0] act, input int exp);
        logic [13:0] e14;
        e14 = 14'(exp);
        total++;
        if (act !== e14) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, $signed(act), exp);
        end
    endtask

    // Model capture and per-cycle compare
    always @(posedge clk) begin
        exp_t e;
        int   yr, yi;
        cyc++;
        if (rstn && bus.din_valid) begin
            e.due = cyc + 2;
            e.fs  = (mbeat == 0);
            for (int l = 0; l < 16; l++) begin
                model_lane(int'($signed(bus.din_sub_r[l])), int'($signed(bus.din_sub_i[l])),
                           mbeat * 16 + l, yr, yi);
                e.sr[l] = yr[13:0];
                e.si[l] = yi[13:0];
                e.ar[l] = 14'($signed(bus.din_add_r[l]));
                e.ai[l] = 14'($signed(bus.din_add_i[l]));
            end
            q.push_back(e);
            mbeat = (mbeat + 1) % 16;
        end
        #1;
        while (q.size() > 0 && q[0].due < cyc) begin
            chk_i("missing_beat", 0, 1);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk_i("dout_valid", int'(bus.dout_valid), 1);
            chk_i("frame_start", int'(bus.dout_frame_start), int'(e.fs));
            chk_v("sub_r", bus.dout_sub_r, e.sr);
            chk_v("sub_i", bus.dout_sub_i, e.si);
            chk_v("add_r", bus.dout_add_r, e.ar);
            chk_v("add_i", bus.dout_add_i, e.ai);
        end else begin
            chk_i("dout_valid_idle", int'(bus.dout_valid), 0);
            chk_i("frame_start_idle", int'(bus.dout_frame_start), 0);
        end
        if (bus.dout_frame_start) begin
            fs_cnt++;
            fs_pos.push_back(out_idx);
        end
        if (bus.dout_valid) out_idx++;
    end

    function automatic int rv();
        return int'($urandom_range(8192)) - 4096;
    endfunction

    task automatic beat(input int sr, input int si, input int ar, input int ai);
        @(negedge clk);
        bus.din_valid = 1'b1;
        for (int l = 0; l < 16; l++) begin
            bus.din_sub_r[l] = 13'(rv());
            bus.din_sub_i[l] = 13'(rv());
            bus.din_add_r[l] = 13'(rv());
            bus.din_add_i[l] = 13'(rv());
        end
        bus.din_sub_r[0] = 13'(sr);
        bus.din_sub_i[0] = 13'(si);
        bus.din_add_r[0] = 13'(ar);
        bus.din_add_i[0] = 13'(ai);
    endtask

    task automatic beat_rand();
        beat(rv(), rv(), rv(), rv());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.din_valid = 1'b0;
        rstn = 1'b0;
        q.delete();
        mbeat = 0;
        #1;
        chk_i("rst_valid", int'(bus.dout_valid), 0);
        chk_i("rst_fs", int'(bus.dout_frame_start), 0);
        chk_v("rst_sub_r", bus.dout_sub_r, '0);
        chk_v("rst_sub_i", bus.dout_sub_i, '0);
        chk_v("rst_add_r", bus.dout_add_r, '0);
        chk_v("rst_add_i", bus.dout_add_i, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Wait until the last driven beat has reached the outputs
    task automatic wait_out();
        idle(2);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.din_add_r = '0;
        bus.din_add_i = '0;
        bus.din_sub_r = '0;
        bus.din_sub_i = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // 1: beat 0, n=0 is unity
        beat(100, -50, 5, -5);
        wait_out();
        chk_i("t1_valid", int'(bus.dout_valid), 1);
        chk_i("t1_fs", int'(bus.dout_frame_start), 1);
        chk_l("t1_sub_r", bus.dout_sub_r[0], 100);
        chk_l("t1_sub_i", bus.dout_sub_i[0], -50);

        // 2: beat 8, lane 0 is n=128 -> multiply by -j
        for (int b = 1; b < 8; b++) beat_rand();
        beat(100, -50, -7, 3);
        wait_out();
        chk_l("t2_sub_r", bus.dout_sub_r[0], -50);
        chk_l("t2_sub_i", bus.dout_sub_i[0], -100);
        chk_l("t2_add_r", bus.dout_add_r[0], -7);
        chk_l("t2_add_i", bus.dout_add_i[0], 3);
        chk_i("t2_fs", int'(bus.dout_frame_start), 0);

        // 3: beat 4, lane 0 is n=64
        do_reset();
        for (int b = 0; b < 4; b++) beat_rand();
        beat(1, 0, 0, 0);
        wait_out();
`ifdef STEP0_TW_ROUND_EN
        chk_l("t3_round_r", bus.dout_sub_r[0], 1);
`else
        chk_l("t3_floor_r", bus.dout_sub_r[0], 0);
`endif
        chk_l("t3_sub_i", bus.dout_sub_i[0], -1);

        do_reset();
        for (int b = 0; b < 4; b++) beat_rand();
        beat(-4096, -4096, -4096, 4095);
        wait_out();
        chk_l("t3_big_r", bus.dout_sub_r[0], -5792);
        chk_l("t3_big_i", bus.dout_sub_i[0], 0);
        chk_l("t3_add_r", bus.dout_add_r[0], -4096);
        chk_l("t3_add_i", bus.dout_add_i[0], 4095);

        // 4: one frame with bubbles after beats 5 and 11
        do_reset();
        fs_cnt = 0;
        for (int b = 0; b < 16; b++) begin
            beat_rand();
            if (b == 5 || b == 11) idle(3);
        end
        idle(6);
        chk_i("t4_fs_once", fs_cnt, 1);

        // 5: 40 back-to-back beats
        do_reset();
        fs_pos.delete();
        out_idx = 0;
        for (int b = 0; b < 40; b++) beat_rand();
        idle(6);
        chk_i("t5_fs_count", fs_pos.size(), 3);
        if (fs_pos.size() == 3) begin
            chk_i("t5_fs0", fs_pos[0], 0);
            chk_i("t5_fs1", fs_pos[1], 16);
            chk_i("t5_fs2", fs_pos[2], 32);
        end

        // 6: reset after beat 7; aborted beats must never appear
        do_reset();
        for (int b = 0; b < 8; b++) beat_rand();
        do_reset();
        idle(5);
        beat(100, -50, 1, 2);
        wait_out();
        chk_i("t6_valid", int'(bus.dout_valid), 1);
        chk_i("t6_fs", int'(bus.dout_frame_start), 1);
        chk_l("t6_sub_r", bus.dout_sub_r[0], 100);
        chk_l("t6_sub_i", bus.dout_sub_i[0], -50);

        idle(6);
        chk_i("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
